cram_backup_arbiter: RTL and testbench
======================================

Name: cram_backup_arbiter

Overview:
- Shares the single-port cartridge RAM between the CPU path (mapper-translated cram address) and a battery-backup engine.
- The backup engine streams 512-byte sectors between cart RAM and the SD sector buffer for save and load.
- The CPU always wins. Backup accesses use only the idle cycles where ce_cpu is low.
- Sits between the active mapper's cram outputs and the cart RAM macro; the host save/load logic drives the bk_* request port.

Parameters:
- SECTOR_AW, 9, byte-address width within one sector (512 bytes).
- RAM_AW, 17, cart RAM byte-address width (128 KB max).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ce_cpu  in  1  CPU slot strobe; RAM belongs to the CPU this cycle.
- cpu_cram_addr  in  17  mapper cram address.
- cpu_cram_wr  in  1  CPU write, already qualified by RAM enable.
- cpu_cram_di  in  8  CPU write data.
- cpu_cram_do  out  8  CPU read data, held between slots.
- ram_mask  in  4  mapper RAM bank mask; RAM size = (ram_mask+1)*8 KB.
- bk_req  in  1  start-transfer pulse.
- bk_dir  in  1  0 = save (RAM->buffer), 1 = load (buffer->RAM).
- bk_lba  in  8  sector index within cart RAM.
- bk_busy  out  1  transfer in progress.
- bk_done  out  1  one-cycle completion pulse.
- bk_err  out  1  last request rejected (lba out of range); sticky until next bk_req.
- buf_addr  out  9  sector buffer address.
- buf_rdata  in  8  buffer read data, 1-cycle latency.
- buf_wdata  out  8  buffer write data.
- buf_wr  out  1  buffer write strobe.
- ram_addr  out  17  RAM address.
- ram_wr  out  1  RAM write strobe.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid the cycle after the address.

Behaviour:
- Reset (async, reset_n low):
  - State IDLE.
  - All outputs 0, including cpu_cram_do, bk_busy, bk_done, bk_err, buf_wr and ram_wr.
  - Byte counter 0.
- RAM mux:
  - ce_cpu=1: ram_addr=cpu_cram_addr, ram_wr=cpu_cram_wr, ram_wdata=cpu_cram_di.
  - ce_cpu=0: backup engine drives the RAM if its state needs it; otherwise ram_wr=0 and ram_addr holds its last value.
- CPU read: in the cycle after a ce_cpu=1 cycle, cpu_cram_do <= ram_rdata and holds until the next such capture. The CPU sees no extra latency from backup activity.
- Request acceptance:
  - bk_req is accepted only in IDLE. It is ignored while busy.
  - In-range test: bk_lba < (ram_mask+1)*16. If the test fails: bk_err=1 and bk_done pulses the next cycle, with no transfer.
  - If the test passes: bk_busy=1, the latched base = {bk_lba, 9'd0}, and the counter is reset to 0.
- Save path, SAVE_RD -> SAVE_CAP -> SAVE_WB:
  - SAVE_RD: waits for ce_cpu=0, then presents base+cnt.
  - SAVE_CAP: unconditionally latches ram_rdata into a hold register. This is correct even if ce_cpu=1 in this cycle.
  - SAVE_WB: buf_wr=1, buf_addr=cnt, buf_wdata=hold. The buffer is private, so this step is not gated by ce_cpu.
  - After SAVE_WB: cnt+1. If cnt was 511, go to DONE; otherwise return to SAVE_RD.
- Load path, LOAD_RD -> LOAD_CAP -> LOAD_WR:
  - LOAD_RD: buf_addr=cnt.
  - LOAD_CAP: latches buf_rdata.
  - LOAD_WR: waits for ce_cpu=0, then ram_wr=1 at base+cnt with the latched byte.
  - After LOAD_WR: cnt+1. If cnt was 511, go to DONE.
- DONE: bk_done=1 for one cycle, bk_busy=0, then IDLE.
- Throughput: at most one byte per 3 cycles, fewer when ce_cpu is dense. Completion is guaranteed as long as ce_cpu is not held high permanently.
- Counter: 9 bits. Wrap from 511 ends the transfer. Addresses never cross the sector.
- Reset mid-transfer: aborts immediately. No bk_done is issued and any partial sector is left as written.
- Simultaneous CPU write and pending backup write to the same byte: the CPU write lands first (its slot), and the backup write follows. In load mode the loaded data wins, by design.

Optional Feature:
- Macro: CRAM_BACKUP_DIRTY_EN.
- With the macro:
  - Adds output port dirty (1 bit), reset 0.
  - Set on any cycle with ce_cpu & cpu_cram_wr.
  - Cleared when a save transfer reaches DONE, unless a CPU write happens in that same DONE cycle (set wins).
  - A load transfer clears dirty at DONE.
- Without the macro: the port is absent and there is no dirty logic.

Decomposition:
- Package gb_cram_pkg:
  - state enum (IDLE, SAVE_RD, SAVE_CAP, SAVE_WB, LOAD_RD, LOAD_CAP, LOAD_WR, DONE);
  - SECTOR_BYTES=512;
  - RAM_AW=17;
  - direction constants DIR_SAVE=0, DIR_LOAD=1.
- No sub-module: the FSM, counter and mux stay flat in one module.

Test Plan:
- ram_mask=0, RAM preloaded addr=i -> i[7:0]; save lba=0, ce_cpu never high -> buffer[i]=i[7:0] for i=0..511; bk_done after about 1536 cycles; bk_err=0.
- ram_mask=3, lba=64 (limit 64) -> bk_err=1; bk_done the next cycle; no ram_wr/buf_wr pulses; bk_busy stays 0.
- Load lba=5 with buffer[j]=~j, ce_cpu toggling every other cycle -> RAM 0x0A00..0x0BFF=~j; no ram_wr in any ce_cpu=1 cycle from the engine.
- During a save, CPU reads 0x1234 (value 0x5A) in a ce_cpu slot aligned with SAVE_CAP -> cpu_cram_do=0x5A; the saved buffer still matches RAM.
- reset_n low at cnt=200 of a load -> all outputs 0 asynchronously; no bk_done; RAM 0..199 written, 200+ untouched.
- CRAM_BACKUP_DIRTY_EN: CPU write to 0x0010 -> dirty=1; full save -> dirty=0 after DONE; CPU write in the DONE cycle -> dirty stays 1.

Source files
------------

// File: rtl/gb_cram_pkg.sv
// Shared types and constants for the cart RAM / battery-backup arbiter.
// Holds the engine state encoding, sector geometry and transfer direction codes.
// Also provides the sector range check used when a backup request is accepted.
package gb_cram_pkg;

   localparam int SECTOR_BYTES = 512;
   localparam int SECTOR_AW    = 9;
   localparam int RAM_AW       = 17;

   localparam logic DIR_SAVE = 1'b0;
   localparam logic DIR_LOAD = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      SAVE_RD,
      SAVE_CAP,
      SAVE_WB,
      LOAD_RD,
      LOAD_CAP,
      LOAD_WR,
      DONE
   } bk_state_t;

   // RAM holds (mask+1) 8 KB banks, i.e. 16 sectors per bank
   function automatic logic lba_in_range(input logic [7:0] lba, input logic [3:0] mask);
      logic [8:0] limit;
      limit = ({5'd0, mask} + 9'd1) << 4;
      return ({1'b0, lba} < limit);
   endfunction

endpackage

// File: rtl/cram_backup_arbiter.sv
// Purpose: shares single-port cart RAM between the CPU slot and a 512-byte sector backup engine.
// Latency: CPU path is combinational to the RAM, read data captured 1 cycle after the slot; engine moves 1 byte per >=3 cycles.
// Backpressure: ce_cpu always wins; engine RAM steps stall while ce_cpu=1. CRAM_BACKUP_DIRTY_EN adds the dirty output.
module cram_backup_arbiter
   import gb_cram_pkg::*;
#(
   parameter int SECTOR_AW = 9,
   parameter int RAM_AW    = 17
)(
   input  logic                          clk_sys,
   input  logic                          reset_n,
   input  logic                          ce_cpu,
   input  logic [RAM_AW-1:0]             cpu_cram_addr,
   input  logic                          cpu_cram_wr,
   input  logic [7:0]                    cpu_cram_di,
   output logic [7:0]                    cpu_cram_do,
   input  logic [3:0]                    ram_mask,
   input  logic                          bk_req,
   input  logic                          bk_dir,
   input  logic [RAM_AW-SECTOR_AW-1:0]   bk_lba,
   output logic                          bk_busy,
   output logic                          bk_done,
   output logic                          bk_err,
   output logic [SECTOR_AW-1:0]          buf_addr,
   input  logic [7:0]                    buf_rdata,
   output logic [7:0]                    buf_wdata,
   output logic                          buf_wr,
   output logic [RAM_AW-1:0]             ram_addr,
   output logic                          ram_wr,
   output logic [7:0]                    ram_wdata,
`ifdef CRAM_BACKUP_DIRTY_EN
   output logic                          dirty,
`endif
   input  logic [7:0]                    ram_rdata
);

   localparam int LBA_W = RAM_AW - SECTOR_AW;

   bk_state_t               state;
   logic [SECTOR_AW-1:0]    cnt;
   logic [LBA_W-1:0]        lba_q;
   logic [7:0]              hold;
   logic [RAM_AW-1:0]       addr_q;
   logic                    cpu_slot;
   logic                    cpu_slot_q;
   logic                    eng_rd;
   logic                    eng_wr;
   logic                    last_byte;
   logic [RAM_AW-1:0]       eng_addr;

   // reset_n gates the CPU path so the RAM port is quiet while in reset
   assign cpu_slot  = ce_cpu & reset_n;
   assign eng_rd    = (state == SAVE_RD) & ~ce_cpu;
   assign eng_wr    = (state == LOAD_WR) & ~ce_cpu;
   assign last_byte = (cnt == SECTOR_AW'(SECTOR_BYTES - 1));
   // sector base is lba << 9, so base+cnt is a plain concatenation
   assign eng_addr  = {lba_q, cnt};

   // buffer side is private to the engine: address tracks the byte counter
   assign buf_addr  = cnt;
   assign buf_wdata = hold;

   // RAM port mux: CPU slot first, then engine, else park on the last address
   always_comb begin
      ram_addr  = addr_q;
      ram_wr    = 1'b0;
      ram_wdata = 8'h00;
      if (cpu_slot) begin
         ram_addr  = cpu_cram_addr;
         ram_wr    = cpu_cram_wr;
         ram_wdata = cpu_cram_di;
      end else if (eng_rd) begin
         ram_addr  = eng_addr;
      end else if (eng_wr) begin
         ram_addr  = eng_addr;
         ram_wr    = 1'b1;
         ram_wdata = hold;
      end
   end

   // remember the presented address and capture CPU read data one cycle after its slot
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         addr_q      <= '0;
         cpu_slot_q  <= 1'b0;
         cpu_cram_do <= 8'h00;
      end else begin
         addr_q     <= ram_addr;
         cpu_slot_q <= cpu_slot;
         if (cpu_slot_q)
            cpu_cram_do <= ram_rdata;
      end
   end

   // backup engine FSM with registered busy/done/buffer-write strobes
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         lba_q   <= '0;
         hold    <= 8'h00;
         bk_busy <= 1'b0;
         bk_done <= 1'b0;
         bk_err  <= 1'b0;
         buf_wr  <= 1'b0;
      end else begin
         bk_done <= 1'b0;
         buf_wr  <= 1'b0;
         case (state)
            IDLE: begin
               if (bk_req) begin
                  if (lba_in_range(bk_lba, ram_mask)) begin
                     bk_err  <= 1'b0;
                     bk_busy <= 1'b1;
                     lba_q   <= bk_lba;
                     cnt     <= '0;
                     state   <= (bk_dir == DIR_LOAD) ? LOAD_RD : SAVE_RD;
                  end else begin
                     // rejected: completion pulse without any transfer
                     bk_err  <= 1'b1;
                     bk_done <= 1'b1;
                     state   <= DONE;
                  end
               end
            end
            SAVE_RD: begin
               if (!ce_cpu)
                  state <= SAVE_CAP;
            end
            SAVE_CAP: begin
               // data belongs to the engine's read even if the CPU owns this slot
               hold   <= ram_rdata;
               buf_wr <= 1'b1;
               state  <= SAVE_WB;
            end
            SAVE_WB: begin
               cnt <= cnt + 1'b1;
               if (last_byte) begin
                  bk_busy <= 1'b0;
                  bk_done <= 1'b1;
                  state   <= DONE;
               end else begin
                  state   <= SAVE_RD;
               end
            end
            LOAD_RD: begin
               state <= LOAD_CAP;
            end
            LOAD_CAP: begin
               hold  <= buf_rdata;
               state <= LOAD_WR;
            end
            LOAD_WR: begin
               if (!ce_cpu) begin
                  cnt <= cnt + 1'b1;
                  if (last_byte) begin
                     bk_busy <= 1'b0;
                     bk_done <= 1'b1;
                     state   <= DONE;
                  end else begin
                     state   <= LOAD_RD;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef CRAM_BACKUP_DIRTY_EN
   // CPU writes mark the RAM dirty; a completed transfer (bk_err low) clears it, a same-cycle write wins
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         dirty <= 1'b0;
      else if (cpu_slot && cpu_cram_wr)
         dirty <= 1'b1;
      else if ((state == DONE) && !bk_err)
         dirty <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_cram_backup_arbiter.sv
// Bench for cram_backup_arbiter: RAM and sector-buffer models plus a scoreboard of expected engine writes.
// Each scenario task drives its own stimulus and compares inline; one summary line at the end.
// Build with CRAM_BACKUP_DIRTY_EN defined to also exercise the dirty flag.
module tb_cram_backup_arbiter;
   import gb_cram_pkg::*;

   logic         clk_sys;
   logic         reset_n;
   logic         ce_cpu;
   logic [16:0]  cpu_cram_addr;
   logic         cpu_cram_wr;
   logic [7:0]   cpu_cram_di;
   logic [7:0]   cpu_cram_do;
   logic [3:0]   ram_mask;
   logic         bk_req;
   logic         bk_dir;
   logic [7:0]   bk_lba;
   logic         bk_busy;
   logic         bk_done;
   logic         bk_err;
   logic [8:0]   buf_addr;
   logic [7:0]   buf_rdata;
   logic [7:0]   buf_wdata;
   logic         buf_wr;
   logic [16:0]  ram_addr;
   logic         ram_wr;
   logic [7:0]   ram_wdata;
   logic [7:0]   ram_rdata;
`ifdef CRAM_BACKUP_DIRTY_EN
   logic         dirty;
`endif

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [16:0] addr;
      logic [7:0]  dat;
   } exp_t;
   exp_t sb[$];

   logic [7:0] ram_mem [0:131071];
   logic [7:0] buf_mem [0:511];
   int  ram_pat = 0;
   int  buf_pat = 0;
   bit  ram_go = 0, ram_seen = 0;
   bit  buf_go = 0, buf_seen = 0;

   cram_backup_arbiter dut (
      .clk_sys       (clk_sys),
      .reset_n       (reset_n),
      .ce_cpu        (ce_cpu),
      .cpu_cram_addr (cpu_cram_addr),
      .cpu_cram_wr   (cpu_cram_wr),
      .cpu_cram_di   (cpu_cram_di),
      .cpu_cram_do   (cpu_cram_do),
      .ram_mask      (ram_mask),
      .bk_req        (bk_req),
      .bk_dir        (bk_dir),
      .bk_lba        (bk_lba),
      .bk_busy       (bk_busy),
      .bk_done       (bk_done),
      .bk_err        (bk_err),
      .buf_addr      (buf_addr),
      .buf_rdata     (buf_rdata),
      .buf_wdata     (buf_wdata),
      .buf_wr        (buf_wr),
      .ram_addr      (ram_addr),
      .ram_wr        (ram_wr),
      .ram_wdata     (ram_wdata),
`ifdef CRAM_BACKUP_DIRTY_EN
      .dirty         (dirty),
`endif
      .ram_rdata     (ram_rdata)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   function automatic logic [7:0] ram_fill(input int a, input int p);
      logic [16:0] av;
      av = a[16:0];
      if (p == 1) return 8'hEE;
      if (av == 17'h01234) return 8'h5A;
      return av[7:0];
   endfunction

   function automatic logic [7:0] buf_fill(input int j, input int p);
      logic [8:0] jv;
      jv = j[8:0];
      if (p == 1) return ~jv[7:0];
      return 8'h00;
   endfunction

   // RAM model: registered read, write-after-read, bulk fill on request
   always @(posedge clk_sys) begin
      if (ram_go != ram_seen) begin
         for (int i = 0; i < 131072; i++) ram_mem[i] = ram_fill(i, ram_pat);
         ram_seen = ram_go;
      end
      ram_rdata <= ram_mem[ram_addr];
      if (ram_wr) ram_mem[ram_addr] = ram_wdata;
   end

   // sector buffer model: 1-cycle read latency
   always @(posedge clk_sys) begin
      if (buf_go != buf_seen) begin
         for (int j = 0; j < 512; j++) buf_mem[j] = buf_fill(j, buf_pat);
         buf_seen = buf_go;
      end
      buf_rdata <= buf_mem[buf_addr];
      if (buf_wr) buf_mem[buf_addr] = buf_wdata;
   end

   task automatic fill_models(input int rp, input int bp);
      ram_pat = rp;
      buf_pat = bp;
      ram_go  = ~ram_go;
      buf_go  = ~buf_go;
      @(posedge clk_sys); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b1; ce_cpu = 1'b0; cpu_cram_addr = '0; cpu_cram_wr = 1'b0;
      cpu_cram_di = '0; ram_mask = '0; bk_req = 1'b0; bk_dir = 1'b0; bk_lba = '0;
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clk_sys);
      n_vec++; if ({bk_busy, bk_done, bk_err} !== 3'b000) begin n_err++; $display("FAIL reset_status: got %b expected 000", {bk_busy, bk_done, bk_err}); end
      n_vec++; if ({buf_wr, ram_wr} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b expected 00", {buf_wr, ram_wr}); end
      n_vec++; if (ram_addr !== 17'h0) begin n_err++; $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); end
      n_vec++; if (cpu_cram_do !== 8'h00) begin n_err++; $display("FAIL reset_cpu_do: got %h expected 00", cpu_cram_do); end
      n_vec++; if ({buf_addr, buf_wdata, ram_wdata} !== 25'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", {buf_addr, buf_wdata, ram_wdata}); end
      @(posedge clk_sys); #1 reset_n = 1'b1;
   endtask

   task automatic test_save_basic();
      exp_t e;
      bit done_seen = 0;
      int done_cyc = -1;
      fill_models(0, 0);
      ram_mask = 4'd0; bk_lba = 8'd0; bk_dir = DIR_SAVE;
      for (int i = 0; i < 512; i++) sb.push_back('{17'(i), ram_fill(i, 0)});
      for (int k = 0; k < 3000 && !done_seen; k++) begin
         @(posedge clk_sys); #1 bk_req = (k == 0);
         @(negedge clk_sys);
         if (k == 1) begin
            n_vec++; if ({bk_busy, bk_err} !== 2'b10) begin n_err++; $display("FAIL save_start: busy,err got %b expected 10", {bk_busy, bk_err}); end
         end
         if (ram_wr) begin n_vec++; n_err++; $display("FAIL save_ram_wr: got 1 expected 0 at k=%0d", k); end
         if (buf_wr) begin
            n_vec++;
            if (sb.size() == 0) begin n_err++; $display("FAIL save_extra_wr: got write at %h expected none", buf_addr); end
            else begin
               e = sb.pop_front();
               if ({buf_addr, buf_wdata} !== {e.addr[8:0], e.dat}) begin
                  n_err++; $display("FAIL save_buf: got %h/%h expected %h/%h", buf_addr, buf_wdata, e.addr[8:0], e.dat);
               end
            end
         end
         if (bk_done) begin done_seen = 1; done_cyc = k; end
      end
      n_vec++; if (done_cyc !== 1537) begin n_err++; $display("FAIL save_done_cycle: got %0d expected 1537", done_cyc); end
      n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL save_left: got %0d expected 0", sb.size()); end
      n_vec++; if ({bk_busy, bk_err} !== 2'b00) begin n_err++; $display("FAIL save_end: busy,err got %b expected 00", {bk_busy, bk_err}); end
      sb.delete();
      @(negedge clk_sys);
      n_vec++; if (bk_done !== 1'b0) begin n_err++; $display("FAIL save_done_pulse: got %b expected 0", bk_done); end
   endtask

   task automatic test_reject();
      ram_mask = 4'd3; bk_lba = 8'd64; bk_dir = DIR_SAVE;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk_sys); #1 bk_req = (k == 0);
         @(negedge clk_sys);
         n_vec++; if ({buf_wr, ram_wr, bk_busy} !== 3'b000) begin n_err++; $display("FAIL rej_quiet: got %b expected 000", {buf_wr, ram_wr, bk_busy}); end
         n_vec++; if (bk_done !== (k == 1)) begin n_err++; $display("FAIL rej_done k=%0d: got %b expected %b", k, bk_done, (k == 1)); end
         if (k >= 1) begin
            n_vec++; if (bk_err !== 1'b1) begin n_err++; $display("FAIL rej_err k=%0d: got %b expected 1", k, bk_err); end
         end
      end
   endtask

   task automatic test_load_toggle();
      exp_t e;
      bit done_seen = 0;
      fill_models(1, 1);
      ram_mask = 4'd3; bk_lba = 8'd5; bk_dir = DIR_LOAD;
      cpu_cram_addr = 17'h0; cpu_cram_wr = 1'b0;
      for (int j = 0; j < 512; j++) sb.push_back('{17'h00A00 + 17'(j), buf_fill(j, 1)});
      for (int k = 0; k < 6000 && !done_seen; k++) begin
         @(posedge clk_sys); #1;
         bk_req = (k == 0) || (k == 700);
         if (k == 700) begin bk_lba = 8'd1; bk_dir = DIR_SAVE; end
         ce_cpu = (k % 2 == 1);
         @(negedge clk_sys);
         if (k == 1) begin
            n_vec++; if ({bk_busy, bk_err} !== 2'b10) begin n_err++; $display("FAIL load_start: busy,err got %b expected 10", {bk_busy, bk_err}); end
         end
         if (buf_wr) begin n_vec++; n_err++; $display("FAIL load_buf_wr: got 1 expected 0 at k=%0d", k); end
         if (ce_cpu) begin
            n_vec++; if (ram_wr !== 1'b0) begin n_err++; $display("FAIL load_wr_in_slot: got 1 expected 0 at k=%0d", k); end
         end else if (ram_wr) begin
            n_vec++;
            if (sb.size() == 0) begin n_err++; $display("FAIL load_extra_wr: got write at %h expected none", ram_addr); end
            else begin
               e = sb.pop_front();
               if ({ram_addr, ram_wdata} !== {e.addr, e.dat}) begin
                  n_err++; $display("FAIL load_ram: got %h/%h expected %h/%h", ram_addr, ram_wdata, e.addr, e.dat);
               end
            end
         end
         if (bk_done) done_seen = 1;
      end
      ce_cpu = 1'b0; bk_req = 1'b0;
      n_vec++; if (done_seen !== 1'b1) begin n_err++; $display("FAIL load_done: got 0 expected 1"); end
      n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL load_left: got %0d expected 0", sb.size()); end
      sb.delete();
      @(negedge clk_sys);
      for (int j = 0; j < 512; j++) begin
         n_vec++;
         if (ram_mem[17'h00A00 + 17'(j)] !== buf_fill(j, 1)) begin
            n_err++; $display("FAIL load_mem[%0d]: got %h expected %h", j, ram_mem[17'h00A00 + 17'(j)], buf_fill(j, 1));
         end
      end
      n_vec++; if ({ram_mem[17'h009FF], ram_mem[17'h00C00]} !== 16'hEEEE) begin n_err++; $display("FAIL load_bounds: got %h%h expected EEEE", ram_mem[17'h009FF], ram_mem[17'h00C00]); end
   endtask

   task automatic test_cpu_read_in_save();
      exp_t e;
      bit done_seen = 0;
      int done_cyc = -1;
      fill_models(0, 0);
      ram_mask = 4'd0; bk_lba = 8'd9; bk_dir = DIR_SAVE;
      cpu_cram_addr = 17'h01234; cpu_cram_wr = 1'b0;
      for (int i = 0; i < 512; i++) sb.push_back('{17'(i), ram_fill(17'h01200 + i, 0)});
      for (int k = 0; k < 3000 && !done_seen; k++) begin
         @(posedge clk_sys); #1;
         bk_req = (k == 0);
         ce_cpu = (k == 152);
         @(negedge clk_sys);
         if (k == 1) begin
            n_vec++; if (ram_addr !== 17'h01200) begin n_err++; $display("FAIL cpurd_eng_addr: got %h expected 01200", ram_addr); end
         end
         if (k == 152) begin
            n_vec++; if (ram_addr !== 17'h01234) begin n_err++; $display("FAIL cpurd_slot_addr: got %h expected 01234", ram_addr); end
         end
         if (k == 154) begin
            n_vec++; if (cpu_cram_do !== 8'h5A) begin n_err++; $display("FAIL cpurd_data: got %h expected 5a", cpu_cram_do); end
         end
         if (buf_wr) begin
            n_vec++;
            if (sb.size() == 0) begin n_err++; $display("FAIL cpurd_extra_wr: got write at %h expected none", buf_addr); end
            else begin
               e = sb.pop_front();
               if ({buf_addr, buf_wdata} !== {e.addr[8:0], e.dat}) begin
                  n_err++; $display("FAIL cpurd_buf: got %h/%h expected %h/%h", buf_addr, buf_wdata, e.addr[8:0], e.dat);
               end
            end
         end
         if (bk_done) begin done_seen = 1; done_cyc = k; end
      end
      n_vec++; if (done_cyc !== 1537) begin n_err++; $display("FAIL cpurd_done_cycle: got %0d expected 1537", done_cyc); end
      n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL cpurd_left: got %0d expected 0", sb.size()); end
      n_vec++; if (cpu_cram_do !== 8'h5A) begin n_err++; $display("FAIL cpurd_hold: got %h expected 5a", cpu_cram_do); end
      sb.delete();
   endtask

   task automatic test_reset_mid_load();
      int wr_cnt = 0;
      fill_models(1, 1);
      ram_mask = 4'd0; bk_lba = 8'd0; bk_dir = DIR_LOAD; ce_cpu = 1'b0;
      for (int k = 0; k < 1000 && wr_cnt < 200; k++) begin
         @(posedge clk_sys); #1 bk_req = (k == 0);
         @(negedge clk_sys);
         if (ram_wr) begin
            n_vec++;
            if ({ram_addr, ram_wdata} !== {17'(wr_cnt), buf_fill(wr_cnt, 1)}) begin
               n_err++; $display("FAIL rstld_wr: got %h/%h expected %h/%h", ram_addr, ram_wdata, 17'(wr_cnt), buf_fill(wr_cnt, 1));
            end
            wr_cnt++;
         end
      end
      n_vec++; if (wr_cnt !== 200) begin n_err++; $display("FAIL rstld_count: got %0d expected 200", wr_cnt); end
      @(posedge clk_sys); #2 reset_n = 1'b0;
      #1;
      n_vec++; if ({bk_busy, bk_done, bk_err, buf_wr, ram_wr} !== 5'b0) begin n_err++; $display("FAIL rstld_async: got %b expected 00000", {bk_busy, bk_done, bk_err, buf_wr, ram_wr}); end
      n_vec++; if ({ram_addr, buf_addr, cpu_cram_do, ram_wdata} !== 42'h0) begin n_err++; $display("FAIL rstld_async_data: got %h expected 0", {ram_addr, buf_addr, cpu_cram_do, ram_wdata}); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_sys);
         n_vec++; if (bk_done !== 1'b0) begin n_err++; $display("FAIL rstld_no_done: got 1 expected 0"); end
      end
      n_vec++; if ({ram_mem[0], ram_mem[199]} !== 16'hFF38) begin n_err++; $display("FAIL rstld_written: got %h%h expected ff38", ram_mem[0], ram_mem[199]); end
      n_vec++; if ({ram_mem[200], ram_mem[511]} !== 16'hEEEE) begin n_err++; $display("FAIL rstld_untouched: got %h%h expected eeee", ram_mem[200], ram_mem[511]); end
      @(posedge clk_sys); #1 reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk_sys);
         n_vec++; if ({bk_busy, bk_done, ram_wr} !== 3'b000) begin n_err++; $display("FAIL rstld_after: got %b expected 000", {bk_busy, bk_done, ram_wr}); end
      end
   endtask

`ifdef CRAM_BACKUP_DIRTY_EN
   task automatic test_dirty();
      bit done_seen;
      fill_models(0, 0);
      n_vec++; if (dirty !== 1'b0) begin n_err++; $display("FAIL dirty_reset: got %b expected 0", dirty); end
      @(posedge clk_sys); #1;
      ce_cpu = 1'b1; cpu_cram_wr = 1'b1; cpu_cram_addr = 17'h00010; cpu_cram_di = 8'h77;
      @(posedge clk_sys); #1;
      ce_cpu = 1'b0; cpu_cram_wr = 1'b0;
      @(negedge clk_sys);
      n_vec++; if (dirty !== 1'b1) begin n_err++; $display("FAIL dirty_set: got %b expected 1", dirty); end
      for (int pass = 0; pass < 2; pass++) begin
         ram_mask = 4'd0; bk_lba = 8'd0; bk_dir = DIR_SAVE;
         done_seen = 0;
         for (int k = 0; k < 3000 && !done_seen; k++) begin
            @(posedge clk_sys); #1;
            bk_req = (k == 0);
            ce_cpu = (pass == 1) && (k == 1537);
            cpu_cram_wr = ce_cpu;
            @(negedge clk_sys);
            if (bk_done) done_seen = 1;
         end
         @(posedge clk_sys); #1 ce_cpu = 1'b0; cpu_cram_wr = 1'b0;
         @(negedge clk_sys);
         n_vec++;
         if (dirty !== (pass == 1)) begin n_err++; $display("FAIL dirty_after_save%0d: got %b expected %b", pass, dirty, (pass == 1)); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_save_basic();
      test_reject();
      test_load_toggle();
      test_cpu_read_in_save();
      test_reset_mid_load();
`ifdef CRAM_BACKUP_DIRTY_EN
      test_dirty();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
